// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared allocator state type, index types and default sizes.
package switch_allocator_pkg;
  localparam int NUM_IN_DEF = 4;
  localparam int NUM_OUT_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 256;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_t;
  typedef logic [$clog2(NUM_IN_DEF)-1:0] in_idx_t;
  typedef logic [$clog2(NUM_OUT_DEF)-1:0] out_idx_t;
endpackage

// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request/crossbar bundle; timeout_err exists only with SWITCH_ALLOC_TIMEOUT_EN.
interface switch_allocator_if #(
  parameter int NUM_IN = 4,
  parameter int NUM_OUT = 4
);
  localparam int IW = $clog2(NUM_IN);
  localparam int OW = $clog2(NUM_OUT);
  logic [NUM_IN-1:0] req_valid;
  logic [NUM_IN-1:0][OW-1:0] req_dest;
  logic [NUM_IN-1:0] req_last;
  logic [NUM_OUT-1:0] out_ready;
  logic [NUM_IN-1:0] grant;
  logic [NUM_OUT-1:0][IW-1:0] sel;
  logic [NUM_OUT-1:0] enable;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  logic [NUM_OUT-1:0] timeout_err;
  modport master (output req_valid, req_dest, req_last, out_ready, input grant, sel, enable, timeout_err);
  modport slave (input req_valid, req_dest, req_last, out_ready, output grant, sel, enable, timeout_err);
`else
  modport master (output req_valid, req_dest, req_last, out_ready, input grant, sel, enable);
  modport slave (input req_valid, req_dest, req_last, out_ready, output grant, sel, enable);
`endif
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: picks the requester with the smallest distance at or above ptr, wrapping at N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W:0] best, off;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    best = '1;
    off = '0;
    for (int i = 0; i < N; i++) begin
      off = (i >= int'(ptr)) ? (W+1)'(i - int'(ptr)) : (W+1)'(i + N - int'(ptr));
      if (req[i] && off < best) begin
        best = off;
        idx = W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin wormhole allocator driving crossbar sel/enable and input pops.
// Define SWITCH_ALLOC_TIMEOUT_EN to add the per-output stall watchdog and timeout_err.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input logic clk,
  input logic n_rst,
  switch_allocator_if.slave bus
);
  localparam int IW = $clog2(NUM_IN);
  localparam int OW = $clog2(NUM_OUT);
  alloc_state_t state [NUM_OUT];
  logic [NUM_OUT-1:0][IW-1:0] owner, ptr, win;
  logic [NUM_OUT-1:0][NUM_IN-1:0] elig;
  logic [NUM_OUT-1:0] win_valid, xfer, tmo, done;
  logic [NUM_IN-1:0] busy, grant;
  // an input holding any lock may not contend elsewhere
  always_comb begin
    busy = '0;
    grant = '0;
    for (int o = 0; o < NUM_OUT; o++)
      if (state[o] == LOCKED) busy[owner[o]] = 1'b1;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++)
        elig[o][i] = bus.req_valid[i] && bus.req_dest[i] == OW'(o) && !busy[i];
      xfer[o] = state[o] == LOCKED && bus.req_valid[owner[o]] && bus.out_ready[o] && !tmo[o];
      done[o] = (xfer[o] && bus.req_last[owner[o]]) || tmo[o];
      if (xfer[o]) grant[owner[o]] = 1'b1;
    end
  end
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_arb
    rr_arbiter #(.N(NUM_IN)) u_arb (
      .req  (elig[o]),
      .ptr  (ptr[o]),
      .idx  (win[o]),
      .valid(win_valid[o])
    );
  end
  // a freed output idles one cycle before the next allocation
  always_ff @(posedge clk)
    for (int o = 0; o < NUM_OUT; o++)
      if (!n_rst) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o] <= '0;
      end else if (state[o] == IDLE) begin
        if (win_valid[o]) begin
          state[o] <= LOCKED;
          owner[o] <= win[o];
        end
      end else if (done[o]) begin
        state[o] <= IDLE;
        ptr[o] <= owner[o] == IW'(NUM_IN - 1) ? '0 : owner[o] + 1'b1;
      end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_OUT-1:0][CW-1:0] cnt;
  always_comb
    for (int o = 0; o < NUM_OUT; o++)
      tmo[o] = state[o] == LOCKED && cnt[o] == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk)
    for (int o = 0; o < NUM_OUT; o++)
      cnt[o] <= (!n_rst || state[o] == IDLE || xfer[o] || tmo[o]) ? '0 : cnt[o] + 1'b1;
  assign bus.timeout_err = tmo;
`else
  assign tmo = '0;
`endif
  assign bus.grant = grant;
  assign bus.sel = owner;
  assign bus.enable = xfer;
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed and randomized checks against a packet-level allocation model.
module tb_switch_allocator;
  import switch_allocator_pkg::*;
  localparam int NI = 4, NO = 4, TO = 8;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int n_chk = 0, n_fail = 0;
  int q_len [NI][$];
  int q_dest [NI][$];
  logic [NI-1:0] vld_en = '1;
  logic [NO-1:0] rdy = '1;
  int m_lock [NO], m_own [NO], m_ptr [NO], m_cnt [NO];
  int x_lock [NO], x_own [NO], x_ptr [NO], x_cnt [NO];
  logic [NI-1:0] e_grant;
  logic [NO-1:0] e_en, e_tmo;
  logic [NO-1:0][1:0] e_sel;
  always #5 clk = ~clk;
  switch_allocator_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  switch_allocator #(.NUM_IN(NI), .NUM_OUT(NO), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`else
  switch_allocator #(.NUM_IN(NI), .NUM_OUT(NO)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`endif
  task automatic push(input int i, input int len, input int dest);
    q_len[i].push_back(len);
    q_dest[i].push_back(dest);
  endtask
  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      bus.req_valid[i] = q_len[i].size() > 0 && vld_en[i];
      bus.req_last[i] = q_len[i].size() > 0 && q_len[i][0] == 1;
      bus.req_dest[i] = q_len[i].size() > 0 ? out_idx_t'(q_dest[i][0]) : '0;
    end
    bus.out_ready = rdy;
  endtask
  // packet-level model: who should hold each output and what moves this cycle
  function automatic void model_eval();
    bit busy [NI];
    int w, c;
    bit x, t;
    e_grant = '0; e_en = '0; e_tmo = '0;
    for (int i = 0; i < NI; i++) busy[i] = 0;
    for (int o = 0; o < NO; o++) if (m_lock[o] != 0) busy[m_own[o]] = 1;
    for (int o = 0; o < NO; o++) begin
      e_sel[o] = 2'(m_own[o]);
      x_lock[o] = m_lock[o]; x_own[o] = m_own[o]; x_ptr[o] = m_ptr[o]; x_cnt[o] = 0;
      if (m_lock[o] != 0) begin
        t = TMO_ON && m_cnt[o] == TO;
        x = bus.req_valid[m_own[o]] && rdy[o] && !t;
        e_en[o] = x; e_tmo[o] = t;
        if (x) e_grant[m_own[o]] = 1'b1;
        if ((x && bus.req_last[m_own[o]]) || t) begin
          x_lock[o] = 0;
          x_ptr[o] = (m_own[o] + 1) % NI;
        end else x_cnt[o] = x ? 0 : m_cnt[o] + 1;
      end else begin
        w = -1;
        for (int k = 0; k < NI; k++) begin
          c = (m_ptr[o] + k) % NI;
          if (w < 0 && bus.req_valid[c] && int'(bus.req_dest[c]) == o && !busy[c]) w = c;
        end
        if (w >= 0) begin x_lock[o] = 1; x_own[o] = w; end
      end
    end
  endfunction
  task automatic settle();
    drive();
    @(negedge clk);
    model_eval();
  endtask
  task automatic advance();
    @(posedge clk);
    for (int o = 0; o < NO; o++) begin
      m_lock[o] = n_rst ? x_lock[o] : 0; m_own[o] = n_rst ? x_own[o] : 0;
      m_ptr[o] = n_rst ? x_ptr[o] : 0; m_cnt[o] = n_rst ? x_cnt[o] : 0;
    end
    for (int i = 0; i < NI; i++)
      if (e_grant[i] && q_len[i].size() > 0) begin
        q_len[i][0] = q_len[i][0] - 1;
        if (q_len[i][0] == 0) begin
          void'(q_len[i].pop_front());
          void'(q_dest[i].pop_front());
        end
      end
    #1;
  endtask
  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < NI; i++) if (q_len[i].size() > 0) pending = 1;
    for (int o = 0; o < NO; o++) if (m_lock[o] != 0) pending = 1;
  endfunction
  task automatic drain();
    int g = 0;
    vld_en = '1; rdy = '1;
    while (pending() && g < 300) begin settle(); advance(); g++; end
    n_chk++;
    if (g >= 300) begin n_fail++; $display("FAIL drain_timeout: still pending after %0d cycles, want idle", g); end
  endtask
  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) begin settle(); advance(); end
    n_rst = 1'b1;
    repeat (4) begin
      settle();
      n_chk += 3;
      if (bus.enable !== '0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", bus.enable); end
      if (bus.grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
      if (bus.sel !== '0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", bus.sel); end
      advance();
    end
  endtask
  task automatic test_single_flit();
    push(1, 1, 2);
    settle();
    n_chk++;
    if (bus.enable !== 4'b0000 || bus.grant !== 4'b0000) begin n_fail++; $display("FAIL sf_alloc: en %b grant %b want 0 0", bus.enable, bus.grant); end
    advance(); settle();
    n_chk += 3;
    if (bus.enable !== 4'b0100) begin n_fail++; $display("FAIL sf_enable: got %b want 0100", bus.enable); end
    if (bus.sel[2] !== 2'd1) begin n_fail++; $display("FAIL sf_sel: got %0d want 1", bus.sel[2]); end
    if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL sf_grant: got %b want 0010", bus.grant); end
    advance(); settle();
    n_chk++;
    if (bus.enable !== 4'b0000) begin n_fail++; $display("FAIL sf_release: en %b want 0000", bus.enable); end
    advance();
    push(1, 1, 2); push(2, 1, 2);
    settle(); advance(); settle();
    n_chk++;
    if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL sf_ptr: grant %b want 0100", bus.grant); end
    advance();
    drain();
  endtask
  task automatic test_round_robin();
    int order[$];
    int g = 0, got;
    for (int r = 0; r < 5; r++) for (int i = 0; i < NI; i++) push(i, 1, 0);
    while (order.size() < 5 && g < 60) begin
      settle();
      for (int i = 0; i < NI; i++) if (bus.grant[i]) order.push_back(i);
      advance(); g++;
    end
    for (int k = 0; k < 5; k++) begin
      got = k < order.size() ? order[k] : -1;
      n_chk++;
      if (got != k % NI) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got, k % NI); end
    end
    drain();
  endtask
  task automatic test_wormhole();
    int order[$];
    int first = -1, last4 = -1, g = 0, got;
    int want[5] = '{2, 2, 2, 2, 0};
    push(2, 4, 1);
    settle(); advance();
    push(0, 1, 1);
    while (order.size() < 5 && g < 40) begin
      settle();
      for (int i = 0; i < NI; i++) if (bus.grant[i]) begin
        order.push_back(i);
        if (order.size() == 1) first = g;
        if (order.size() == 4) last4 = g;
      end
      advance(); g++;
    end
    for (int k = 0; k < 5; k++) begin
      got = k < order.size() ? order[k] : -1;
      n_chk++;
      if (got != want[k]) begin n_fail++; $display("FAIL worm_order[%0d]: got %0d want %0d", k, got, want[k]); end
    end
    n_chk++;
    if (last4 - first != 3) begin n_fail++; $display("FAIL worm_consecutive: span %0d want 3", last4 - first); end
    drain();
  endtask
  task automatic test_backpressure();
    int cnt = 0, g = 0;
    push(1, 6, 3);
    while (cnt < 2 && g < 20) begin settle(); if (bus.grant[1]) cnt++; advance(); g++; end
    rdy[3] = 1'b0;
    repeat (5) begin
      settle();
      n_chk += 3;
      if (bus.grant[1] !== 1'b0) begin n_fail++; $display("FAIL bp_grant: got %b want 0", bus.grant[1]); end
      if (bus.enable[3] !== 1'b0) begin n_fail++; $display("FAIL bp_enable: got %b want 0", bus.enable[3]); end
      if (bus.sel[3] !== 2'd1) begin n_fail++; $display("FAIL bp_sel: got %0d want 1", bus.sel[3]); end
      advance();
    end
    rdy[3] = 1'b1;
    g = 0;
    while (g < 40) begin settle(); if (bus.grant[1]) cnt++; advance(); g++; end
    n_chk++;
    if (cnt != 6) begin n_fail++; $display("FAIL bp_total: got %0d flits want 6", cnt); end
    drain();
  endtask
  task automatic test_mid_reset();
    int order[$];
    int g = 0, got;
    bit seen = 0;
    push(2, 3, 0);
    while (!seen && g < 20) begin settle(); seen = bus.grant[2]; advance(); g++; end
    vld_en = '0; n_rst = 1'b0;
    settle(); advance();
    n_rst = 1'b1; vld_en = '1;
    push(0, 1, 0);
    settle();
    n_chk++;
    if (bus.enable !== '0 || bus.grant !== '0) begin n_fail++; $display("FAIL mr_idle: en %b grant %b want 0 0", bus.enable, bus.grant); end
    advance();
    g = 0;
    while (order.size() < 2 && g < 30) begin
      settle();
      for (int i = 0; i < NI; i++) if (bus.grant[i]) order.push_back(i);
      advance(); g++;
    end
    got = order.size() > 0 ? order[0] : -1;
    n_chk++;
    if (got != 0) begin n_fail++; $display("FAIL mr_ptr_first: got %0d want 0", got); end
    got = order.size() > 1 ? order[1] : -1;
    n_chk++;
    if (got != 2) begin n_fail++; $display("FAIL mr_ptr_second: got %0d want 2", got); end
    drain();
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (q_len[i].size() == 0 && $urandom_range(0, 9) < 3) push(i, $urandom_range(1, 4), $urandom_range(0, NO - 1));
        vld_en[i] = $urandom_range(0, 99) < 85;
      end
      for (int o = 0; o < NO; o++) rdy[o] = $urandom_range(0, 99) < 75;
      settle();
      n_chk += 3;
      if (bus.grant !== e_grant) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, bus.grant, e_grant); end
      if (bus.enable !== e_en) begin n_fail++; $display("FAIL rand_enable c%0d: got %b want %b", c, bus.enable, e_en); end
      if (bus.sel !== e_sel) begin n_fail++; $display("FAIL rand_sel c%0d: got %h want %h", c, bus.sel, e_sel); end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      n_chk++;
      if (bus.timeout_err !== e_tmo) begin n_fail++; $display("FAIL rand_tmo c%0d: got %b want %b", c, bus.timeout_err, e_tmo); end
`endif
      advance();
    end
    drain();
  endtask
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0, g = 0;
    bit seen = 0, got1 = 0;
    push(0, 3, 2);
    while (!seen && g < 20) begin settle(); seen = bus.grant[0]; advance(); g++; end
    vld_en[0] = 1'b0;
    push(1, 1, 2);
    repeat (30) begin
      settle();
      n_chk++;
      if (bus.timeout_err !== e_tmo) begin n_fail++; $display("FAIL tmo_pulse: got %b want %b", bus.timeout_err, e_tmo); end
      if (bus.timeout_err[2]) pulses++;
      if (bus.grant[1]) got1 = 1;
      advance();
    end
    n_chk += 2;
    if (pulses != 1) begin n_fail++; $display("FAIL tmo_count: got %0d pulses want 1", pulses); end
    if (!got1) begin n_fail++; $display("FAIL tmo_realloc: in1 granted %0d want 1", got1); end
    drain();
  endtask
`endif
  initial begin
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_mid_reset();
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output wormhole allocator feeding the switch crossbar.
- Arbitrates input-port requests for each output with round-robin fairness.
- Holds each grant from head flit to tail flit.
- Drives the crossbar select and enable lines, and returns per-input flit-consumed grants to the input buffers.

Parameters:
- NUM_IN, 4, number of switch input ports (must be >= 2).
- NUM_OUT, 4, number of switch output ports (must be >= 2).
- TIMEOUT_CYCLES, 256, stall limit for the optional watchdog (must be >= 1).

Ports:
- clk  input  1  clock.
- n_rst  input  1  synchronous active-low reset.
- req_valid  input  NUM_IN  input i presents a flit.
- req_dest  input  NUM_IN x $clog2(NUM_OUT)  destination output of input i's current packet; stable from head to tail.
- req_last  input  NUM_IN  flit on input i is the packet tail.
- out_ready  input  NUM_OUT  downstream of output o can accept a flit this cycle.
- grant  output  NUM_IN  input i's flit is transferred this cycle (pop).
- sel  output  NUM_OUT x $clog2(NUM_IN)  crossbar select per output.
- enable  output  NUM_OUT  crossbar output o drives a valid flit this cycle.
- timeout_err  output  NUM_OUT  watchdog pulse; present only with the optional feature.

Behaviour:
- One clock (clk); reset is synchronous and active-low (n_rst).
- Per-output state alloc_state_t: IDLE, LOCKED. Per output o, registered: state[o], owner[o] (NUM_IN index), ptr[o] (round-robin pointer).
- Reset values: state = IDLE, owner = 0, ptr = 0, stall count = 0. Outputs after reset: sel = 0, enable = 0, grant = 0, timeout_err = 0.
- Reset asserted mid-packet forces IDLE on the next edge. The lock is dropped and no release pointer update is applied.
- Eligibility: input i requests output o when req_valid[i] && req_dest[i]==o && input i is not owner of any LOCKED output.
- IDLE, no eligible requester: stay IDLE, enable[o] = 0.
- IDLE, one or more eligible requesters:
  - Winner = first eligible index at or above ptr[o], wrapping modulo NUM_IN.
  - Next cycle: state = LOCKED, owner = winner.
  - enable[o] = 0 in the allocation cycle; allocation latency is 1 cycle.
- LOCKED:
  - sel[o] = owner[o] (combinational from register).
  - xfer[o] = req_valid[owner] && out_ready[o]. enable[o] = xfer[o].
  - grant[i] = OR over o of (xfer[o] && owner[o]==i).
- Release: when xfer[o] && req_last[owner] in LOCKED:
  - next state = IDLE; ptr[o] = (owner+1) mod NUM_IN.
  - The freed output is not re-allocated in the release cycle (one idle cycle between packets).
- Single-flit packet: allocated, then locked, transferred and released in the first LOCKED cycle with out_ready.
- Backpressure: with out_ready low, the lock is held, no grant, and owner/sel are unchanged.
- Owner deasserts req_valid mid-packet: lock held, enable = 0 (bubble), no release.
- Simultaneous same-cycle allocations on different outputs are independent.
- An input contends for one output only (single dest), so it is never granted on two outputs.
- sel[o] when IDLE: holds the last owner value, so the crossbar input is unchanged; enable gates validity.
- Index arithmetic: pointer wrap uses modulo NUM_IN. Index widths are $clog2 of the port count, so non-power-of-two counts must wrap at NUM_IN-1, not at 2^width.

Optional Feature:
- Macro: SWITCH_ALLOC_TIMEOUT_EN.
- Defined:
  - Per-output stall counter increments each LOCKED cycle without xfer and clears on xfer or IDLE.
  - On reaching TIMEOUT_CYCLES: force IDLE, ptr = owner+1, pulse timeout_err[o] for 1 cycle. No grant is issued that cycle.
- Undefined:
  - No counters; the lock is held indefinitely.
  - timeout_err port absent.

Decomposition:
- Shared switch package: alloc_state_t enum (IDLE, LOCKED), in/out index typedefs parameterised by $clog2 widths, TIMEOUT_CYCLES default constant.
- One sub-module, rr_arbiter: combinational NUM_IN-wide round-robin pick from a request vector and pointer. Outputs are the winner index and a valid flag. Instantiated NUM_OUT times.

Test Plan:
- Reset then idle: n_rst low 2 cycles, then no requests -> enable = 0, grant = 0, sel = 0 every cycle.
- Single-flit packet: in1 valid, dest=2, last=1, out_ready=1 -> cycle+1: enable[2]=1, sel[2]=1, grant[1]=1; cycle+2: enable[2]=0 (IDLE), ptr[2]=2.
- Round-robin contention: in0..in3 all send 1-flit packets to out0 continuously -> service order 0,1,2,3,0. Each grant is separated by alloc and release idle cycles.
- Wormhole lock: in2 sends 4-flit packet to out1 while in0 also requests out1 -> in2 gets 4 consecutive grants; in0 is granted only after in2's tail.
- Backpressure: out_ready[3]=0 for 5 cycles mid-packet -> no grant, sel unchanged, lock held; flow resumes on out_ready=1 with no flit lost.
- With SWITCH_ALLOC_TIMEOUT_EN and TIMEOUT_CYCLES=8: owner holds req_valid=0 for 8 locked cycles -> timeout_err pulses exactly once, output returns to IDLE, next requester allocated.
